// File: rtl/pe_requant_pack.sv
// rtl/pe_requant_pack.sv - requantize PE accumulators to clamped bytes, pack into words, buffer in a FIFO
module pe_requant_pack #(
  parameter int ACC_W      = 38,
  parameter int FRAC       = 16,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [ACC_W-1:0]              in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  output logic [8*PACK-1:0]             out_data,
  output logic [PACK-1:0]               out_keep,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int KW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 8*PACK + PACK + 1;
  localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (FRAC-1);

  logic                  s1_valid, s1_last;
  logic [ACC_W:0]        s1_r;
  logic signed [ACC_W:0] s1_q;
  logic [7:0]            clamp_byte;
  logic                  s2_valid, s2_last;
  logic [7:0]            s2_byte;

  logic [KW-1:0]         k;
  logic [8*PACK-1:0]     stage_data, pk_data;
  logic [PACK-1:0]       stage_keep, pk_keep;
  logic                  push;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  full, pop, wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
    end
  end

  // Round half-up: add 0.5 in one extra bit of headroom so the sum cannot wrap.
  always_ff @(posedge clk) begin
    s1_r    <= {in_data[ACC_W-1], in_data} + HALF;
    s1_last <= in_last;
    s2_byte <= clamp_byte;
    s2_last <= s1_last;
  end

  assign s1_q = $signed(s1_r) >>> FRAC;

  always_comb begin
    clamp_byte = s1_q[7:0];
    if (s1_q[ACC_W])
      clamp_byte = 8'h00;
    else if (|s1_q[ACC_W-1:8])
      clamp_byte = 8'hFF;
  end

  always_comb begin
    pk_data = stage_data;
    pk_keep = stage_keep;
    for (int i = 0; i < PACK; i++) begin
      if (k == KW'(i)) begin
        pk_data[8*i +: 8] = s2_byte;
        pk_keep[i]        = 1'b1;
      end
    end
    push = s2_valid && ((k == KW'(PACK-1)) || s2_last);
  end

  // The lane counter clears on every push, including a dropped one.
  always_ff @(posedge clk) begin
    if (rst) begin
      k          <= '0;
      stage_data <= '0;
      stage_keep <= '0;
    end else if (s2_valid) begin
      if (push) begin
        k          <= '0;
        stage_data <= '0;
        stage_keep <= '0;
      end else begin
        k          <= k + KW'(1);
        stage_data <= pk_data;
        stage_keep <= pk_keep;
      end
    end
  end

  assign out_valid = (fifo_level != '0);
  assign full      = (fifo_level == LW'(FIFO_DEPTH));
  assign pop       = out_valid && out_ready;
  assign wr_en     = push && (!full || pop);
  assign {out_last, out_keep, out_data} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {s2_last, pk_keep, pk_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (push && full && !pop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_requant_pack.sv
// tb/tb_pe_requant_pack.sv - self-checking bench for pe_requant_pack against a queue-based model
module tb_pe_requant_pack;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_last, out_ready;
  logic [37:0] in_data;
  logic        out_valid, out_last, overflow;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic [3:0]  fifo_level;

  pe_requant_pack #(.ACC_W(38), .FRAC(16), .PACK(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .out_ready(out_ready), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 0;

  typedef struct {logic [31:0] d; logic [3:0] k; bit l;} wrd_t;
  typedef struct {bit v; int b; bit l;} stg_t;
  wrd_t mq[$];
  int   pend[$];
  stg_t d1, d2;
  bit   m_ovf;

  // Requantized byte: floor(x / 2^16 + 0.5), clamped to 0..255.
  function automatic int rq(longint x);
    longint q;
    q = (x + 32768) >>> 16;
    if (q < 0) return 0;
    if (q > 255) return 255;
    return int'(q);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(bit r, bit v, longint x, bit l, bit rdy);
    bit   pop, full, push;
    wrd_t w;
    if (r) begin
      mq.delete();
      pend.delete();
      d1 = '{0, 0, 0};
      d2 = '{0, 0, 0};
      m_ovf = 0;
      return;
    end
    pop  = (mq.size() > 0) && rdy;
    full = (mq.size() == 8);
    push = 0;
    w    = '{32'h0, 4'h0, 0};
    if (d2.v) begin
      pend.push_back(d2.b);
      if (pend.size() == 4 || d2.l) begin
        for (int i = 0; i < pend.size(); i++) begin
          w.d[8*i +: 8] = 8'(pend[i]);
          w.k[i]        = 1'b1;
        end
        w.l = d2.l;
        pend.delete();
        push = 1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (full && !pop) m_ovf = 1;
      else mq.push_back(w);
    end
    d2 = d1;
    d1 = '{v, rq(x), l};
  endtask

  task automatic step(bit r, bit v, longint x, bit l, bit rdy);
    logic [63:0] xv;
    xv        = x;
    rst       = r;
    in_valid  = v;
    in_data   = xv[37:0];
    in_last   = l;
    out_ready = rdy;
    @(posedge clk);
    model_edge(r, v, x, l, rdy);
    if (r) cmp_en = 1;
    #1;
  endtask

  task automatic idle(bit rdy, int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, rdy);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid", out_valid, mq.size() != 0);
      chk("fifo_level", fifo_level, mq.size());
      chk("overflow", overflow, m_ovf);
      if (mq.size() > 0) begin
        chk("out_data", out_data, mq[0].d);
        chk("out_keep", out_keep, mq[0].k);
        chk("out_last", out_last, mq[0].l);
      end
    end
  end

  initial begin
    longint vals[5];
    logic [31:0] e;
    int thr;
    bit r, v, l, rdy;
    longint x;

    rst = 1; in_valid = 0; in_data = '0; in_last = 0; out_ready = 0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", overflow, 0);

    // Rounding and clamp
    vals[0] = 'h18000; vals[1] = 'h07FFF; vals[2] = 'h08000;
    vals[3] = -65536;  vals[4] = longint'(300) <<< 16;
    chk("rq_1p5", rq(vals[0]), 2);
    chk("rq_lt_half", rq(vals[1]), 0);
    chk("rq_half", rq(vals[2]), 1);
    chk("rq_neg", rq(vals[3]), 0);
    chk("rq_sat", rq(vals[4]), 255);
    for (int i = 0; i < 5; i++) step(0, 1, vals[i], i == 4, 1);
    idle(1, 1);
    chk("round_word", out_data, 32'h00010002);
    chk("round_keep", out_keep, 4'hF);
    idle(1, 1);
    chk("sat_word", out_data, 32'h000000FF);
    chk("sat_keep", out_keep, 4'h1);
    chk("sat_last", out_last, 1);
    idle(1, 3);

    // Full word and latency
    for (int i = 1; i <= 4; i++) step(0, 1, longint'(i) <<< 16, 0, 1);
    idle(1, 1);
    chk("lat_not_yet", out_valid, 0);
    idle(1, 1);
    chk("lat_valid", out_valid, 1);
    chk("pack_word", out_data, 32'h04030201);
    chk("pack_keep", out_keep, 4'hF);
    chk("pack_last", out_last, 0);
    idle(1, 2);

    // Partial flush on last, then next byte in lane 0
    step(0, 1, longint'(9) <<< 16, 0, 1);
    step(0, 1, longint'(10) <<< 16, 1, 1);
    idle(1, 2);
    chk("part_word", out_data, 32'h00000A09);
    chk("part_keep", out_keep, 4'h3);
    chk("part_last", out_last, 1);
    step(0, 1, longint'(11) <<< 16, 1, 1);
    idle(1, 2);
    chk("lane0_word", out_data, 32'h0000000B);
    chk("lane0_keep", out_keep, 4'h1);
    idle(1, 2);

    // Backpressure and overflow
    for (int i = 0; i < 36; i++) step(0, 1, longint'(i + 1) <<< 16, 0, 0);
    idle(0, 2);
    chk("bp_level", fifo_level, 8);
    chk("bp_ovf", overflow, 1);
    idle(0, 3);
    for (int w = 0; w < 8; w++) begin
      for (int j = 0; j < 4; j++) e[8*j +: 8] = 8'(4*w + j + 1);
      chk("drain_word", out_data, e);
      idle(1, 1);
    end
    chk("drain_empty", out_valid, 0);

    // Full plus simultaneous pop
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 36; i++) step(0, 1, longint'(i + 100) <<< 16, 0, 0);
    idle(0, 1);
    chk("full_pre", fifo_level, 8);
    step(0, 0, 0, 0, 1);
    chk("full_pop_level", fifo_level, 8);
    chk("full_pop_ovf", overflow, 0);
    chk("full_pop_head", out_data, 32'h6B6A6968);
    idle(1, 10);

    // Reset mid-word
    step(0, 1, longint'(2) <<< 16, 0, 1);
    step(0, 1, longint'(3) <<< 16, 0, 1);
    step(1, 0, 0, 0, 1);
    chk("midrst_level", fifo_level, 0);
    for (int i = 4; i <= 7; i++) step(0, 1, longint'(i) <<< 16, 0, 1);
    idle(1, 2);
    chk("midrst_valid", out_valid, 1);
    chk("midrst_word", out_data, 32'h07060504);
    chk("midrst_keep", out_keep, 4'hF);
    idle(1, 3);

    // Random traffic against the model
    thr = 100;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: thr = 20;
          1: thr = 60;
          default: thr = 100;
        endcase
      end
      r   = ($urandom_range(0, 599) == 0);
      v   = ($urandom_range(0, 3) != 0);
      l   = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 99) < thr);
      if ($urandom_range(0, 15) == 0)
        x = (longint'($urandom) <<< 5) - (longint'(1) <<< 36);
      else
        x = longint'(int'($urandom_range(0, 330)) - 20) * 65536 + longint'($urandom_range(0, 65535));
      step(r, v, x, l, rdy);
    end
    idle(1, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
